systolic_ctrl: RTL and testbench
================================

Name: systolic_ctrl

Overview:
- Sequencer for an N x N output-stationary systolic array of fp32 `pe` tiles.
- Per job it:
  - clears all accumulators;
  - reads K operand slices (column k of A, row k of B) from banked operand buffers;
  - skews them onto the array west/north edges and flushes the wavefront;
  - presents the N result rows for readout, one row per cycle.
- Sits between the job-issue logic / operand buffers and the PE array.

Parameters:
- N, 4, array dimension (rows = cols = N); N >= 2
- KW, 8, width of k_len; max inner dimension 2^KW - 1
- RW, $clog2(N), width of c_row_sel

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  job request; sampled only in IDLE
- k_len  in  KW  inner dimension K; latched when start is accepted
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job end
- rd_en  out  1  operand buffer read strobe
- rd_addr  out  KW  slice index k
- a_col_data  in  N*32  A[i][k] in bits [32i+31:32i]; valid 1 cycle after rd_en
- b_row_data  in  N*32  B[k][j] in bits [32j+31:32j]; valid 1 cycle after rd_en
- a_edge  out  N*32  west-edge in_a for row i
- b_edge  out  N*32  north-edge in_b for column j
- pe_clr  out  1  drives reset of every PE
- c_row_valid  out  1  high while a result row is presented
- c_row_sel  out  RW  result row index for the external out_c mux

Behaviour:
- States and durations:
  - IDLE: wait for start.
  - CLEAR: 1 cycle.
  - FEED: k_len cycles.
  - FLUSH: 2N cycles.
  - DRAIN: N cycles.
  - DONE: 1 cycle, then IDLE.
- Timeline (cycle 0 = start sampled high in IDLE):
  - CLEAR = cycle 1.
  - FEED = cycles 2 .. k_len+1.
  - FLUSH = k_len+2 .. k_len+2N+1.
  - DRAIN = k_len+2N+2 .. k_len+3N+1.
  - DONE = k_len+3N+2.
- k_len = 0: FEED is skipped (CLEAR -> FLUSH); the drained rows are all +0.0.
- start while busy is ignored. start held high re-launches a job on the cycle after DONE.
- pe_clr = reset OR (state == CLEAR).
- rd_en is high only in FEED; rd_addr = cycle index within FEED (0 .. k_len-1); otherwise rd_addr = 0.
- Skew buffering:
  - Internal 1-bit valid_d = rd_en delayed 1 cycle (matches buffer read latency).
  - Lane i of A passes through i registers before a_edge[i]; lane 0 is combinational from the registered capture. Same for B lane j to b_edge[j].
  - Each lane carries data gated by valid_d; when not valid it carries +0.0 (32'h0). Zero operands make the PE add 0, so accumulators hold during FLUSH/DRAIN.
- Delay-line storage: N(N-1)/2 words per side.
- PE(i,j) receives slice k at cycle 3+k+i+j and has accumulated its final slice by cycle k_len+2+i+j+1. This is ≤ k_len+2N+1, so FLUSH covers the worst case (i = j = N-1).
- DRAIN: c_row_valid = 1, c_row_sel = 0, 1, …, N-1 on consecutive cycles. Outside DRAIN, c_row_valid = 0 and c_row_sel = 0.
- Reset values:
  - state = IDLE.
  - busy, done, rd_en, c_row_valid = 0.
  - rd_addr, c_row_sel = 0.
  - All skew registers and valid_d = 0, so a_edge and b_edge are all zero.
  - pe_clr = 1 while reset is asserted.
- Reset mid-job: job is abandoned; the next cycle starts in IDLE with skew lanes zeroed; no done pulse.
- Counters: one KW-bit phase counter, reused per state and compared against (k_len-1), (2N-1), (N-1). No wrap-around is ever observed.

Decomposition:
- Shared package `systolic_pkg`:
  - FP_W = 32, FP_ZERO = 32'h0;
  - state enum {IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE}.
- One natural sub-module, `skew_line`, instanced 2N times:
  - parameters DEPTH, W; ports clk, reset, din, dout.
  - DEPTH = 0 is a wire-through.

Test Plan:
- N=4, k_len=1, A column = 1.0 (32'h3F800000), B row = 2.0 (32'h40000000) -> pe_clr at cycle 1; rd_en only at cycle 2 with addr 0; c_row_valid cycles 11–14 with sel 0..3; every out_c = 32'h40000000; done at cycle 15.
- N=4, k_len=3, A = B = 1.0 -> a_edge[3] nonzero only on cycles 6–8; b_edge[2] nonzero only on cycles 5–7; all C = 3.0 (32'h40400000); done at cycle 17.
- k_len=0 -> no rd_en pulse; drained C all 32'h0; done at cycle 14.
- start pulsed during FLUSH of an active job -> ignored; exactly one done; busy stays high.
- reset asserted during FEED (cycle 3) -> next cycle state IDLE, busy=0, a_edge/b_edge all 0; pe_clr=1 during reset; no done.
- start held high across two jobs (k_len=2) -> second CLEAR immediately follows the first DONE (IDLE lasts 1 cycle); second job's results are independent of the first.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array sequencer.
package systolic_pkg;

  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h0;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/systolic_ctrl_skew_line.sv
// Fixed-depth delay line that skews one operand lane onto the array edge.
module skew_line #(
  parameter int DEPTH = 1,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;
    assign dout = din;
  end else begin : g_pipe
    logic [W-1:0] sr_q [DEPTH];
    logic [W-1:0] sr_d [DEPTH];

    always_comb begin
      sr_d[0] = din;
      for (int s = 1; s < DEPTH; s++) begin
        sr_d[s] = sr_q[s-1];
      end
    end

    // Cleared on reset so an abandoned job leaves no operands on the edges.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int s = 0; s < DEPTH; s++) begin
          sr_q[s] <= '0;
        end
      end else begin
        sr_q <= sr_d;
      end
    end

    assign dout = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer for an N x N output-stationary systolic array: clear, feed
// K skewed operand slices, flush the wavefront, then present result rows.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int N  = 4,
  parameter int KW = 8,
  parameter int RW = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [KW-1:0]     k_len,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [KW-1:0]     rd_addr,
  input  logic [N*FP_W-1:0] a_col_data,
  input  logic [N*FP_W-1:0] b_row_data,
  output logic [N*FP_W-1:0] a_edge,
  output logic [N*FP_W-1:0] b_edge,
  output logic              pe_clr,
  output logic              c_row_valid,
  output logic [RW-1:0]     c_row_sel
);

  localparam logic [KW-1:0] FLUSH_LAST = KW'(2 * N - 1);
  localparam logic [KW-1:0] DRAIN_LAST = KW'(N - 1);

  state_e        state_q, state_d;
  logic [KW-1:0] phase_q, phase_d;
  logic [KW-1:0] k_len_q, k_len_d;
  logic          rd_vld_q, rd_vld_d;

  logic [N*FP_W-1:0] a_gated;
  logic [N*FP_W-1:0] b_gated;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    k_len_d     = k_len_q;
    busy        = (state_q != IDLE);
    done        = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = '0;
    c_row_valid = 1'b0;
    c_row_sel   = '0;
    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (start) begin
          state_d = CLEAR;
          k_len_d = k_len;
        end
      end
      CLEAR: begin
        phase_d = '0;
        state_d = (k_len_q == '0) ? FLUSH : FEED;
      end
      FEED: begin
        rd_en   = 1'b1;
        rd_addr = phase_q;
        if (phase_q == k_len_q - KW'(1)) begin
          phase_d = '0;
          state_d = FLUSH;
        end else begin
          phase_d = phase_q + KW'(1);
        end
      end
      FLUSH: begin
        if (phase_q == FLUSH_LAST) begin
          phase_d = '0;
          state_d = DRAIN;
        end else begin
          phase_d = phase_q + KW'(1);
        end
      end
      DRAIN: begin
        c_row_valid = 1'b1;
        c_row_sel   = phase_q[RW-1:0];
        if (phase_q == DRAIN_LAST) begin
          phase_d = '0;
          state_d = DONE;
        end else begin
          phase_d = phase_q + KW'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Buffer data arrives one cycle after the read strobe.
  assign rd_vld_d = rd_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      k_len_q  <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      k_len_q  <= k_len_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  assign pe_clr = reset | (state_q == CLEAR);

  // Invalid cycles feed +0.0 so the PEs keep their sums while the wave drains.
  assign a_gated = rd_vld_q ? a_col_data : {N{FP_ZERO}};
  assign b_gated = rd_vld_q ? b_row_data : {N{FP_ZERO}};

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_line #(.DEPTH(i), .W(FP_W)) u_skew_a (
      .clk   (clk),
      .reset (reset),
      .din   (a_gated[i*FP_W +: FP_W]),
      .dout  (a_edge[i*FP_W +: FP_W])
    );
    skew_line #(.DEPTH(i), .W(FP_W)) u_skew_b (
      .clk   (clk),
      .reset (reset),
      .din   (b_gated[i*FP_W +: FP_W]),
      .dout  (b_edge[i*FP_W +: FP_W])
    );
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl with a small PE-array model fed from the edges.
module tb_systolic_ctrl;

  localparam int N  = 4;
  localparam int KW = 8;
  localparam int RW = 2;

  localparam logic [31:0] F1 = 32'h3F800000;
  localparam logic [31:0] F2 = 32'h40000000;
  localparam logic [31:0] JUNK = 32'hDEADBEEF;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            busy;
  logic            done;
  logic            rd_en;
  logic [KW-1:0]   rd_addr;
  logic [N*32-1:0] a_col_data;
  logic [N*32-1:0] b_row_data;
  logic [N*32-1:0] a_edge;
  logic [N*32-1:0] b_edge;
  logic            pe_clr;
  logic            c_row_valid;
  logic [RW-1:0]   c_row_sel;

  int n_chk = 0;
  int n_err = 0;

  systolic_ctrl #(.N(N), .KW(KW), .RW(RW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .k_len       (k_len),
    .busy        (busy),
    .done        (done),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .a_col_data  (a_col_data),
    .b_row_data  (b_row_data),
    .a_edge      (a_edge),
    .b_edge      (b_edge),
    .pe_clr      (pe_clr),
    .c_row_valid (c_row_valid),
    .c_row_sel   (c_row_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // PE array model: operands are small integers encoded as fp32, so the
  // accumulators can be plain ints.
  int          acc [N][N];
  logic [31:0] ar  [N][N];
  logic [31:0] br  [N][N];

  function automatic int dec(input logic [31:0] w);
    case (w)
      32'h00000000: return 0;
      32'h3F800000: return 1;
      32'h40000000: return 2;
      32'h40400000: return 3;
      default:      return 1000;
    endcase
  endfunction

  function automatic logic [31:0] pe_in_a(input int i, input int j);
    if (j == 0) return a_edge[32*i +: 32];
    else        return ar[i][j-1];
  endfunction

  function automatic logic [31:0] pe_in_b(input int i, input int j);
    if (i == 0) return b_edge[32*j +: 32];
    else        return br[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (pe_clr) begin
          acc[i][j] <= 0;
          ar[i][j]  <= '0;
          br[i][j]  <= '0;
        end else begin
          acc[i][j] <= acc[i][j] + dec(pe_in_a(i, j)) * dec(pe_in_b(i, j));
          ar[i][j]  <= pe_in_a(i, j);
          br[i][j]  <= pe_in_b(i, j);
        end
      end
    end
  end

  // Called at the negedge of cycle 0; checks every later cycle to DONE.
  task automatic run_job(input int k, input logic [31:0] aw, input logic [31:0] bw,
                         input int exp_c, input bit hold, input int poke);
    int  last;
    int  drain0;
    bit  prev_rd;
    bit  seen_done;
    bit  dr;
    last      = k + 3*N + 2;
    drain0    = k + 2*N + 2;
    prev_rd   = 1'b0;
    seen_done = 1'b0;
    chk($sformatf("k%0d busy@0", k), busy, 0);
    start = 1'b1;
    k_len = KW'(k);
    for (int n = 1; n <= last + 5 && !seen_done; n++) begin
      @(negedge clk);
      start      = hold || (n == poke);
      k_len      = 8'hAA;
      a_col_data = prev_rd ? {N{aw}} : {N{JUNK}};
      b_row_data = prev_rd ? {N{bw}} : {N{JUNK}};
      #1;
      dr = (n >= drain0) && (n <= last - 1);
      chk($sformatf("k%0d busy@%0d", k, n), busy, n <= last);
      chk($sformatf("k%0d done@%0d", k, n), done, n == last);
      chk($sformatf("k%0d rd_en@%0d", k, n), rd_en, (n >= 2) && (n <= k + 1));
      chk($sformatf("k%0d rd_addr@%0d", k, n), rd_addr,
          ((n >= 2) && (n <= k + 1)) ? n - 2 : 0);
      chk($sformatf("k%0d pe_clr@%0d", k, n), pe_clr, n == 1);
      chk($sformatf("k%0d c_row_valid@%0d", k, n), c_row_valid, dr);
      chk($sformatf("k%0d c_row_sel@%0d", k, n), c_row_sel, dr ? n - drain0 : 0);
      for (int i = 0; i < N; i++) begin
        chk($sformatf("k%0d a_edge%0d@%0d", k, i, n), a_edge[32*i +: 32],
            ((n >= 3 + i) && (n <= 2 + i + k)) ? aw : 32'h0);
        chk($sformatf("k%0d b_edge%0d@%0d", k, i, n), b_edge[32*i +: 32],
            ((n >= 3 + i) && (n <= 2 + i + k)) ? bw : 32'h0);
      end
      if (dr) begin
        for (int j = 0; j < N; j++) begin
          chk($sformatf("k%0d C[%0d][%0d]", k, n - drain0, j), acc[n - drain0][j], exp_c);
        end
      end
      if (done) seen_done = 1'b1;
      prev_rd = rd_en;
    end
    if (!seen_done) chk($sformatf("k%0d done_timeout", k), 0, 1);
  endtask

  task automatic idle_cycles(input int c, input string tag);
    for (int n = 0; n < c; n++) begin
      @(negedge clk);
      #1;
      chk($sformatf("%s busy+%0d", tag, n), busy, 0);
      chk($sformatf("%s done+%0d", tag, n), done, 0);
      chk($sformatf("%s rd_en+%0d", tag, n), rd_en, 0);
      chk($sformatf("%s pe_clr+%0d", tag, n), pe_clr, 0);
      chk($sformatf("%s a_edge+%0d", tag, n), a_edge, 0);
      chk($sformatf("%s b_edge+%0d", tag, n), b_edge, 0);
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    k_len      = '0;
    a_col_data = {N{JUNK}};
    b_row_data = {N{JUNK}};
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst rd_en", rd_en, 0);
    chk("rst rd_addr", rd_addr, 0);
    chk("rst c_row_valid", c_row_valid, 0);
    chk("rst c_row_sel", c_row_sel, 0);
    chk("rst pe_clr", pe_clr, 1);
    chk("rst a_edge", a_edge, 0);
    chk("rst b_edge", b_edge, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 1.0 x 2.0 over one slice -> every C = 2.0, done at cycle 15
    run_job(1, F1, F2, 2, 1'b0, -1);
    idle_cycles(2, "j1");
    @(negedge clk);

    // 1.0 x 1.0 over three slices -> every C = 3.0, done at cycle 17
    run_job(3, F1, F1, 3, 1'b0, -1);
    idle_cycles(2, "j3");
    @(negedge clk);

    // empty job: no reads, C all zero, done at cycle 14
    run_job(0, F1, F2, 0, 1'b0, -1);
    idle_cycles(2, "j0");
    @(negedge clk);

    // start pulsed in FLUSH (cycles 4..11 for k=2) must be ignored
    run_job(2, F1, F1, 2, 1'b0, 6);
    idle_cycles(4, "poke");
    @(negedge clk);

    // reset during FEED abandons the job
    start = 1'b1;
    k_len = 8'd3;
    a_col_data = {N{F1}};
    b_row_data = {N{F1}};
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("mid a_edge0@3", a_edge[31:0], F1);
    reset = 1'b1;
    #1;
    chk("mid pe_clr@3", pe_clr, 1);
    chk("mid busy@3", busy, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid busy@4", busy, 0);
    chk("mid rd_en@4", rd_en, 0);
    chk("mid a_edge@4", a_edge, 0);
    chk("mid b_edge@4", b_edge, 0);
    a_col_data = {N{JUNK}};
    b_row_data = {N{JUNK}};
    idle_cycles(20, "mid");
    @(negedge clk);

    // start held across two jobs: second CLEAR follows DONE after one IDLE
    run_job(2, F1, F1, 2, 1'b1, -1);
    @(negedge clk);
    run_job(2, F1, F2, 4, 1'b0, -1);
    idle_cycles(3, "b2b");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
    $fatal(1);
  end

endmodule
